// File: rtl/icache_controller_pkg.sv
// Shared geometry, address-field positions and FSM encodings for the
// direct-mapped instruction cache.
package icache_controller_pkg;

  localparam int INDEX_BITS      = 3;
  localparam int TAG_BITS        = 3;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int NUM_LINES       = 1 << INDEX_BITS;
  localparam int WORD_BITS       = 32;
  localparam int BLOCK_BITS      = WORDS_PER_BLOCK * WORD_BITS;
  localparam int OFFSET_BITS     = $clog2(WORDS_PER_BLOCK);

  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = 4;
  localparam int TAG_LSB    = 7;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEM_READ = 2'd1;
  localparam logic [1:0] ST_UPDATE   = 2'd2;

  typedef logic [BLOCK_BITS-1:0] block_t;
  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [INDEX_BITS-1:0] index_t;

endpackage

// File: rtl/icache_word_select.sv
// Picks one 32-bit instruction word out of a 128-bit cache line by offset;
// word 0 sits in the least significant bits.
module icache_word_select
  import icache_controller_pkg::*;
(
  input  logic [BLOCK_BITS-1:0]  block_i,
  input  logic [OFFSET_BITS-1:0] offset_i,
  output logic [WORD_BITS-1:0]   word_o
);

  always_comb begin
    word_o = block_i[31:0];
    case (offset_i)
      2'd0:    word_o = block_i[31:0];
      2'd1:    word_o = block_i[63:32];
      2'd2:    word_o = block_i[95:64];
      2'd3:    word_o = block_i[127:96];
      default: word_o = block_i[31:0];
    endcase
  end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: zero-stall hits, and on a miss a
// stall through BUSYWAIT while one 4-word block is fetched from memory.
module icache_controller
  import icache_controller_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  logic [OFFSET_BITS-1:0] pcOffset;
  index_t                 pcIndex;
  tag_t                   pcTag;
  logic                   unusedPcBits;

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  block_t               data_q [NUM_LINES];
  block_t               fill_q;
  index_t               fillIndex_q;
  tag_t                 fillTag_q;

  logic                 inIdle, inRead, inUpdate;
  logic                 hit;
  logic [WORD_BITS-1:0] selectedWord;

  assign pcOffset     = PC[OFFSET_LSB +: OFFSET_BITS];
  assign pcIndex      = PC[INDEX_LSB +: INDEX_BITS];
  assign pcTag        = PC[TAG_LSB +: TAG_BITS];
  assign unusedPcBits = ^{PC[31:TAG_LSB+TAG_BITS], PC[OFFSET_LSB-1:0]};

  assign inIdle   = (state_q == ST_IDLE);
  assign inRead   = (state_q == ST_MEM_READ);
  assign inUpdate = (state_q == ST_UPDATE);

  assign hit = valid_q[pcIndex] && (tag_q[pcIndex] == pcTag);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (!hit) state_d = ST_MEM_READ;
      ST_MEM_READ: if (!MEM_BUSYWAIT) state_d = ST_UPDATE;
      ST_UPDATE:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Reset clears only control state; stale line contents are harmless once invalid.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (inUpdate) valid_q[fillIndex_q] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (inRead && !MEM_BUSYWAIT) begin
      fill_q      <= MEM_READDATA;
      fillIndex_q <= pcIndex;
      fillTag_q   <= pcTag;
    end
    if (RESET && inUpdate) begin
      data_q[fillIndex_q] <= fill_q;
      tag_q[fillIndex_q]  <= fillTag_q;
    end
  end

  icache_word_select u_word_select (
    .block_i  (data_q[pcIndex]),
    .offset_i (pcOffset),
    .word_o   (selectedWord)
  );

  // Every output is forced quiet while RESET is held low.
  assign BUSYWAIT    = RESET && (!inIdle || !hit);
  assign MEM_READ    = RESET && inRead;
  assign MEM_ADDRESS = MEM_READ ? {pcTag, pcIndex} : 6'h00;
  assign INSTRUCTION = RESET ? selectedWord : 32'h0;

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench: behavioural block memory with programmable latency plus a
// valid/tag reference model predicting hits, stall lengths and returned words.
module tb_icache_controller;

   logic         CLK;
   logic         RESET;
   logic [31:0]  PC;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   int checks = 0;
   int failures = 0;

   logic [127:0] memArr [64];
   int           memLatency = 0;
   int           memCnt = 0;

   bit refValid [8];
   int refTag [8];

   icache_controller dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory model: busy for memLatency cycles of a request, then returns the block;
   // outside requests it drives noise that the cache must ignore.
   initial begin
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = '0;
      forever begin
         @(negedge CLK);
         if (MEM_READ === 1'b1) begin
            if (memCnt < memLatency) begin
               MEM_BUSYWAIT = 1'b1;
               MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
               memCnt++;
            end else begin
               MEM_BUSYWAIT = 1'b0;
               MEM_READDATA = memArr[MEM_ADDRESS];
            end
         end else begin
            memCnt = 0;
            MEM_BUSYWAIT = 1'($urandom_range(0, 1));
            MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // Single comparison point used by every check in the bench.
   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   // One fetch from the CPU's point of view: hold PC until BUSYWAIT is low,
   // then compare stall length, memory traffic and the delivered word with the model.
   task automatic applyStimulus(input logic [31:0] pc, input int lat, input string name);
      int           idx;
      int           tg;
      int           busyCycles;
      int           readCycles;
      bit           expHit;
      bit           done;
      logic [5:0]   firstAddr;
      logic [127:0] blk;
      logic [31:0]  expWord;
      int           off;

      idx    = int'(pc[6:4]);
      tg     = int'(pc[9:7]);
      off    = int'(pc[3:2]);
      expHit = refValid[idx] && (refTag[idx] == tg);
      blk    = memArr[pc[9:4]];
      expWord = blk[off*32 +: 32];

      memLatency = lat;
      PC = pc;
      busyCycles = 0;
      readCycles = 0;
      done = 1'b0;
      firstAddr = '0;

      for (int guard = 0; guard < 200 && !done; guard++) begin
         @(negedge CLK);
         #1;
         if (BUSYWAIT !== 1'b1) begin
            done = 1'b1;
         end else begin
            busyCycles++;
            if (MEM_READ === 1'b1) begin
               if (readCycles == 0) firstAddr = MEM_ADDRESS;
               readCycles++;
            end
            @(posedge CLK);
            #1;
         end
      end

      checkOutput({name, "_done"}, 32'(done), 32'd1);
      checkOutput({name, "_stall"}, busyCycles, expHit ? 0 : lat + 3);
      checkOutput({name, "_reads"}, readCycles, expHit ? 0 : lat + 1);
      if (readCycles > 0) checkOutput({name, "_addr"}, 32'(firstAddr), 32'(pc[9:4]));
      checkOutput({name, "_instr"}, INSTRUCTION, expWord);
      checkOutput({name, "_rdIdle"}, 32'(MEM_READ), 32'd0);

      if (!expHit) begin
         refValid[idx] = 1'b1;
         refTag[idx] = tg;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [31:0] rpc;
      int          rlat;
      int          missReads;

      for (int b = 0; b < 64; b++) memArr[b] = {$urandom, $urandom, $urandom, $urandom};
      memArr[0] = 128'h0000000C_00000008_00000004_00000000;
      memArr[8][31:0] = 32'hDEADBEEF;
      for (int i = 0; i < 8; i++) begin
         refValid[i] = 1'b0;
         refTag[i] = 0;
      end

      RESET = 1'b0;
      PC = 32'h0000_03F4;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1;
      checkOutput("rst_busy", 32'(BUSYWAIT), 32'd0);
      checkOutput("rst_read", 32'(MEM_READ), 32'd0);
      checkOutput("rst_addr", 32'(MEM_ADDRESS), 32'd0);
      checkOutput("rst_instr", INSTRUCTION, 32'h0);

      @(posedge CLK);
      #1;
      RESET = 1'b1;
      applyStimulus(32'h0000_0000, 5, "cold");

      applyStimulus(32'h0000_0004, 0, "hit4");
      applyStimulus(32'h0000_0008, 0, "hit8");
      applyStimulus(32'h0000_000C, 0, "hitC");

      applyStimulus(32'h0000_0080, 3, "conflict");
      applyStimulus(32'h0000_0000, 2, "refill0");

      applyStimulus(32'h0000_03F4, 1, "line7");
      applyStimulus(32'hFFFF_FFF5, 0, "hiBits");
      applyStimulus(32'hFFFF_FC01, 0, "hiBits0");

      applyStimulus(32'h0000_0150, 0, "zeroWait");

      // Abort a fill in its third memory cycle; nothing may stay valid afterwards.
      memLatency = 10;
      PC = 32'h0000_01A0;
      missReads = 0;
      for (int guard = 0; guard < 50 && missReads < 3; guard++) begin
         @(negedge CLK);
         #1;
         if (MEM_READ === 1'b1) missReads++;
         if (missReads < 3) begin
            @(posedge CLK);
            #1;
         end
      end
      checkOutput("midRst_reached", missReads, 3);
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("midRst_read", 32'(MEM_READ), 32'd0);
      checkOutput("midRst_busy", 32'(BUSYWAIT), 32'd0);
      RESET = 1'b1;
      for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
      applyStimulus(32'h0000_01A0, 2, "afterRst");
      applyStimulus(32'h0000_0004, 1, "coldAgain");

      for (int n = 0; n < 40; n++) begin
         rpc = $urandom;
         rpc[9:7] = 3'($urandom_range(0, 1));
         rlat = $urandom_range(0, 4);
         applyStimulus(rpc, rlat, $sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
